// File: rtl/ft64_btb_assoc.sv
// ----------------------------------------------------------------------------
// ft64_btb_assoc -- two-way set-associative branch target buffer
//
// Purpose
//   Predicts the next fetch PC for NPORTS independent lookup ports. Each of
//   the 2^LOG_NSETS sets holds two ways (valid, full-address tag, target) and
//   one LRU bit. Lookups take one cycle: pc/npc and the indexed set are
//   registered at edge N, and hit/btgt are resolved from those registers in
//   cycle N+1. After reset an FSM sweeps every set (one per cycle) to clear
//   valid and LRU before predictions are allowed.
//
// Configuration
//   FT64_BTB_ASSOC_CNT_EN : when defined, every way carries a 2-bit saturating
//                           direction counter and a hit also requires the
//                           counter to be >= 2. When undefined, wtaken is
//                           ignored and any valid tag match hits.
//
// Ports
//   clk     in   1               sole clock
//   rst     in   1               synchronous active-high reset
//   wr      in   1               update/allocate strobe
//   wadr    in   AMSB+1          branch PC being updated
//   wdat    in   AMSB+1          resolved branch target
//   wtaken  in   1               resolved direction (counter builds only)
//   winv    in   1               invalidate the entry matching wadr (beats wr)
//   pc      in   NPORTS*(AMSB+1) per-port lookup PC, port k at [k*(AMSB+1) +: AMSB+1]
//   npc     in   NPORTS*(AMSB+1) per-port fallthrough PC, same packing
//   btgt    out  NPORTS*(AMSB+1) predicted next PC (target on hit, else npc)
//   hit     out  NPORTS          per-port predict-taken
//   busy    out  1               clear sweep in progress
// ----------------------------------------------------------------------------
module ft64_btb_assoc #(
    parameter int              AMSB      = 31,
    parameter int              LOG_NSETS = 9,
    parameter int              NPORTS    = 2,
    parameter logic [AMSB:0]   RSTPC     = 32'hFFFC0100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr,
    input  logic [AMSB:0]                wadr,
    input  logic [AMSB:0]                wdat,
    input  logic                         wtaken,
    input  logic                         winv,
    input  logic [NPORTS*(AMSB+1)-1:0]   pc,
    input  logic [NPORTS*(AMSB+1)-1:0]   npc,
    output logic [NPORTS*(AMSB+1)-1:0]   btgt,
    output logic [NPORTS-1:0]            hit,
    output logic                         busy
);

    localparam int AW    = AMSB + 1;
    localparam int NSETS = 1 << LOG_NSETS;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef logic [LOG_NSETS-1:0] idx_t;

    // ------------------------------------------------------------------
    // Storage. Valid and LRU are cleared by the sweep; tag and target
    // never need clearing because valid qualifies them.
    // ------------------------------------------------------------------
    logic [1:0]           valid_mem [NSETS];
    logic                 lru_mem   [NSETS];
    logic [1:0][AMSB:0]   tag_mem   [NSETS];
    logic [1:0][AMSB:0]   tgt_mem   [NSETS];
`ifdef FT64_BTB_ASSOC_CNT_EN
    logic [1:0][1:0]      cnt_mem   [NSETS];
`else
    logic                 unused_wtaken;
    assign unused_wtaken = wtaken;
`endif

    // ------------------------------------------------------------------
    // Clear/run FSM
    // ------------------------------------------------------------------
    logic [0:0] state_q, state_d;
    idx_t       clr_cnt_q, clr_cnt_d;
    logic       clr_active;
    logic       run_active;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + idx_t'(1);
            if (clr_cnt_q == {LOG_NSETS{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy       = (state_q == ST_CLEAR);
    assign clr_active = (state_q == ST_CLEAR) && !rst;
    assign run_active = (state_q == ST_RUN)   && !rst;

    // ------------------------------------------------------------------
    // Update port: read the addressed set, decide invalidate / update /
    // allocate, and write back at the edge.
    // ------------------------------------------------------------------
    idx_t               w_idx;
    logic [1:0]         w_vld;
    logic [1:0][AMSB:0] w_tag;
    logic               w_lru;
    logic               w_m0;
    logic               w_m1;
    logic               w_match;
    logic               sel_way;
    logic               do_inv;
    logic               do_upd;
    logic               do_alloc;

    assign w_idx = wadr[LOG_NSETS+1:2];

    always_comb begin
        w_vld = valid_mem[w_idx];
        w_tag = tag_mem[w_idx];
        w_lru = lru_mem[w_idx];
        // Way 0 takes priority so at most one way is ever selected.
        w_m0    = w_vld[0] && (w_tag[0] == wadr);
        w_m1    = !w_m0 && w_vld[1] && (w_tag[1] == wadr);
        w_match = w_m0 || w_m1;
        sel_way = w_match ? w_m1 : w_lru;
        do_inv   = run_active && winv && w_match;
        do_upd   = run_active && wr && !winv && w_match;
        do_alloc = run_active && wr && !winv && !w_match;
    end

`ifdef FT64_BTB_ASSOC_CNT_EN
    logic [1:0][1:0] w_cnt;
    logic [1:0]      cur_cnt;
    logic [1:0]      new_cnt;

    always_comb begin
        w_cnt   = cnt_mem[w_idx];
        cur_cnt = w_cnt[sel_way];
        if (!w_match) begin
            new_cnt = wtaken ? 2'd2 : 2'd1;
        end else if (wtaken) begin
            new_cnt = (cur_cnt == 2'd3) ? 2'd3 : cur_cnt + 2'd1;
        end else begin
            new_cnt = (cur_cnt == 2'd0) ? 2'd0 : cur_cnt - 2'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (clr_active) begin
            valid_mem[clr_cnt_q] <= 2'b00;
            lru_mem[clr_cnt_q]   <= 1'b0;
        end else if (do_inv) begin
            valid_mem[w_idx][sel_way] <= 1'b0;
        end else if (do_upd || do_alloc) begin
            valid_mem[w_idx][sel_way] <= 1'b1;
            tag_mem[w_idx][sel_way]   <= wadr;
            tgt_mem[w_idx][sel_way]   <= wdat;
            // LRU now names the way that was not just touched.
            lru_mem[w_idx]            <= ~sel_way;
`ifdef FT64_BTB_ASSOC_CNT_EN
            cnt_mem[w_idx][sel_way]   <= new_cnt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Lookup ports. The set is captured at the same edge as any write to
    // it, so a same-cycle lookup sees the old contents.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        idx_t               r_idx;
        logic [AMSB:0]      pc_d, pc_q;
        logic [AMSB:0]      npc_d, npc_q;
        logic [1:0]         vld_d, vld_q;
        logic [1:0][AMSB:0] tag_d, tag_q;
        logic [1:0][AMSB:0] tgt_d, tgt_q;
        logic               m0;
        logic               m1;
        logic               qual;
        logic               hit_k;
        logic [AMSB:0]      btgt_k;
`ifdef FT64_BTB_ASSOC_CNT_EN
        logic [1:0][1:0]    cnt_d, cnt_q;
        logic [1:0]         cnt_sel;
`endif

        always_comb begin
            pc_d  = pc[gi*AW +: AW];
            npc_d = npc[gi*AW +: AW];
            r_idx = pc_d[LOG_NSETS+1:2];
            vld_d = valid_mem[r_idx];
            // The set being swept this cycle is empty from now on.
            if (clr_active && (r_idx == clr_cnt_q)) begin
                vld_d = 2'b00;
            end
            tag_d = tag_mem[r_idx];
            tgt_d = tgt_mem[r_idx];
`ifdef FT64_BTB_ASSOC_CNT_EN
            cnt_d = cnt_mem[r_idx];
`endif
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                npc_q <= RSTPC;
                vld_q <= 2'b00;
            end else begin
                npc_q <= npc_d;
                vld_q <= vld_d;
            end
        end

        always_ff @(posedge clk) begin
            pc_q  <= pc_d;
            tag_q <= tag_d;
            tgt_q <= tgt_d;
`ifdef FT64_BTB_ASSOC_CNT_EN
            cnt_q <= cnt_d;
`endif
        end

        always_comb begin
            m0 = vld_q[0] && (tag_q[0] == pc_q);
            m1 = !m0 && vld_q[1] && (tag_q[1] == pc_q);
`ifdef FT64_BTB_ASSOC_CNT_EN
            cnt_sel = m0 ? cnt_q[0] : cnt_q[1];
            qual    = cnt_sel[1];
`else
            qual    = 1'b1;
`endif
            hit_k  = (state_q == ST_RUN) && (m0 || m1) && qual;
            btgt_k = hit_k ? (m0 ? tgt_q[0] : tgt_q[1]) : npc_q;
        end

        assign hit[gi]           = hit_k;
        assign btgt[gi*AW +: AW] = btgt_k;
    end

endmodule

// File: tb/tb_ft64_btb_assoc.sv
module tb_ft64_btb_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [31:0] wadr;
    logic [31:0] wdat;
    logic        wtaken;
    logic        winv;
    logic [63:0] pc;
    logic [63:0] npc;
    logic [63:0] btgt;
    logic [1:0]  hit;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ft64_btb_assoc dut (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr),
        .wadr   (wadr),
        .wdat   (wdat),
        .wtaken (wtaken),
        .winv   (winv),
        .pc     (pc),
        .npc    (npc),
        .btgt   (btgt),
        .hit    (hit),
        .busy   (busy)
    );

    // Reference model: 512 sets x 2 ways, LRU names the victim way.
    bit          m_valid [512][2];
    logic [31:0] m_tag   [512][2];
    logic [31:0] m_tgt   [512][2];
    int          m_cnt   [512][2];
    bit          m_lru   [512];
    bit          m_run = 1'b0;

    bit          exp_hit  [2];
    logic [31:0] exp_btgt [2];

    function automatic void model_clear();
        for (int s = 0; s < 512; s++) begin
            m_valid[s][0] = 1'b0;
            m_valid[s][1] = 1'b0;
            m_lru[s]      = 1'b0;
        end
    endfunction

    function automatic int model_find(input logic [31:0] a);
        int s;
        s = int'(a[10:2]);
        if (m_valid[s][0] && m_tag[s][0] == a) return 0;
        if (m_valid[s][1] && m_tag[s][1] == a) return 1;
        return -1;
    endfunction

    function automatic void model_lookup(input logic [31:0] p, input logic [31:0] n,
                                         output bit h, output logic [31:0] t);
        int s;
        int w;
        bit q;
        s = int'(p[10:2]);
        w = model_find(p);
        q = 1'b1;
`ifdef FT64_BTB_ASSOC_CNT_EN
        if (w >= 0) q = (m_cnt[s][w] >= 2);
`endif
        h = m_run && (w >= 0) && q;
        t = h ? m_tgt[s][w] : n;
    endfunction

    function automatic void model_write(input bit w, input bit inv, input logic [31:0] a,
                                        input logic [31:0] d, input bit t);
        int s;
        int mw;
        int way;
        s  = int'(a[10:2]);
        mw = model_find(a);
        if (!m_run) return;
        if (inv) begin
            if (mw >= 0) m_valid[s][mw] = 1'b0;
        end else if (w) begin
            way = (mw >= 0) ? mw : int'(m_lru[s]);
            if (mw < 0) m_cnt[s][way] = t ? 2 : 1;
            else if (t) m_cnt[s][way] = (m_cnt[s][way] >= 3) ? 3 : m_cnt[s][way] + 1;
            else        m_cnt[s][way] = (m_cnt[s][way] <= 0) ? 0 : m_cnt[s][way] - 1;
            m_valid[s][way] = 1'b1;
            m_tag[s][way]   = a;
            m_tgt[s][way]   = d;
            m_lru[s]        = (way == 0);
        end
    endfunction

    // One clock: expectations come from the pre-write model (read-before-write).
    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            model_lookup(pc[k*32 +: 32], npc[k*32 +: 32], exp_hit[k], exp_btgt[k]);
        end
        model_write(wr, winv, wadr, wdat, wtaken);
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input bit w, input bit inv, input logic [31:0] a,
                             input logic [31:0] d, input bit t);
        wr = w; winv = inv; wadr = a; wdat = d; wtaken = t;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        set_write(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        pc  = {32'h0000_1000, 32'h0000_2000};
        npc = {32'h1234_5678, 32'h8765_4321};
        @(posedge clk); #1;
        n_total++;
        if (hit !== 2'b00 || btgt !== {32'hFFFC0100, 32'hFFFC0100} || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_outputs: hit=%b btgt=%h busy=%b required hit=00 btgt=fffc0100fffc0100 busy=1",
                     hit, btgt, busy);
        end
        // Partial sweep, then reset again: the sweep must restart from set 0.
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        // Writes during the sweep must be ignored.
        set_write(1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_0000, 1'b1);
        n = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (busy === 1'b1 && hit !== 2'b00) begin
                n_bad++;
                $display("FAIL sweep_hit: cycle=%0d hit=%b required 00", i, hit);
            end
            if (busy === 1'b1) n++;
            else break;
        end
        set_write(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        n_total++;
        if (n != 512) begin
            n_bad++;
            $display("FAIL sweep_length: busy cycles=%0d required 512", n);
        end
        n_total++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_after_sweep: busy=%b required 0", busy);
        end
        model_clear();
        m_run = 1'b1;
        pc  = {32'h0000_1004, 32'h0000_1000};
        npc = {32'h0000_1008, 32'h0000_1004};
        tick();
        n_total++;
        if (hit !== 2'b00 || btgt[31:0] !== 32'h0000_1004) begin
            n_bad++;
            $display("FAIL write_during_sweep: hit=%b btgt0=%h required hit=00 btgt0=00001004",
                     hit, btgt[31:0]);
        end
        $display("reset sweep: busy cycles=%0d", n);
    endtask

    task automatic test_alloc();
        set_write(1'b1, 1'b0, 32'h0000_1000, 32'h0000_2000, 1'b1);
        pc  = {32'h0000_5004, 32'h0000_5000};
        npc = {32'h0000_5008, 32'h0000_5004};
        tick();
        set_write(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        pc  = {32'h0000_1004, 32'h0000_1000};
        npc = {32'h0000_1008, 32'h0000_1004};
        tick();
        n_total++;
        if (hit[0] !== 1'b1 || btgt[31:0] !== 32'h0000_2000) begin
            n_bad++;
            $display("FAIL alloc_hit: hit0=%b btgt0=%h required hit0=1 btgt0=00002000", hit[0], btgt[31:0]);
        end
        n_total++;
        if (hit[1] !== 1'b0 || btgt[63:32] !== 32'h0000_1008) begin
            n_bad++;
            $display("FAIL alloc_miss: hit1=%b btgt1=%h required hit1=0 btgt1=00001008", hit[1], btgt[63:32]);
        end
        $display("alloc: hit=%b btgt=%h", hit, btgt);
    endtask

    task automatic test_lru();
        pc  = {32'h0000_7004, 32'h0000_7000};
        npc = {32'h0000_7008, 32'h0000_7004};
        set_write(1'b1, 1'b0, 32'h0000_1000, 32'h0000_1100, 1'b1); tick();
        set_write(1'b1, 1'b0, 32'h0000_1800, 32'h0000_1900, 1'b1); tick();
        set_write(1'b1, 1'b0, 32'h0000_2000, 32'h0000_2100, 1'b1); tick();
        set_write(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        pc  = {32'h0000_1800, 32'h0000_1000};
        npc = {32'h0000_1804, 32'h0000_1004};
        tick();
        n_total++;
        if (hit !== 2'b10 || btgt !== {32'h0000_1900, 32'h0000_1004}) begin
            n_bad++;
            $display("FAIL lru_evict: hit=%b btgt=%h required hit=10 btgt=0000190000001004", hit, btgt);
        end
        pc  = {32'h0000_1800, 32'h0000_2000};
        npc = {32'h0000_1804, 32'h0000_2004};
        tick();
        n_total++;
        if (hit !== 2'b11 || btgt !== {32'h0000_1900, 32'h0000_2100}) begin
            n_bad++;
            $display("FAIL lru_keep: hit=%b btgt=%h required hit=11 btgt=0000190000002100", hit, btgt);
        end
        $display("lru: hit=%b btgt=%h", hit, btgt);
    endtask

    task automatic test_inv_priority();
        // Re-insert 0x1000 (evicts 0x1800), then winv+wr on it together.
        pc  = {32'h0000_7004, 32'h0000_7000};
        npc = {32'h0000_7008, 32'h0000_7004};
        set_write(1'b1, 1'b0, 32'h0000_1000, 32'h0000_1100, 1'b1); tick();
        set_write(1'b1, 1'b1, 32'h0000_1000, 32'h0000_5555, 1'b1); tick();
        set_write(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        pc  = {32'h0000_2000, 32'h0000_1000};
        npc = {32'h0000_2004, 32'h0000_1004};
        tick();
        n_total++;
        if (hit !== 2'b10 || btgt !== {32'h0000_2100, 32'h0000_1004}) begin
            n_bad++;
            $display("FAIL inv_priority: hit=%b btgt=%h required hit=10 btgt=0000210000001004", hit, btgt);
        end
        $display("inv priority: hit=%b btgt=%h", hit, btgt);
    endtask

    task automatic test_hazard();
        set_write(1'b1, 1'b0, 32'h0000_3000, 32'h0000_3300, 1'b1);
        pc  = {32'h0000_7000, 32'h0000_3000};
        npc = {32'h0000_7004, 32'h0000_3004};
        tick();
        n_total++;
        if (hit[0] !== 1'b0 || btgt[31:0] !== 32'h0000_3004) begin
            n_bad++;
            $display("FAIL hazard_same_cycle: hit0=%b btgt0=%h required hit0=0 btgt0=00003004", hit[0], btgt[31:0]);
        end
        set_write(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        n_total++;
        if (hit[0] !== 1'b1 || btgt[31:0] !== 32'h0000_3300) begin
            n_bad++;
            $display("FAIL hazard_next_cycle: hit0=%b btgt0=%h required hit0=1 btgt0=00003300", hit[0], btgt[31:0]);
        end
        $display("hazard: hit=%b btgt=%h", hit, btgt);
    endtask

`ifdef FT64_BTB_ASSOC_CNT_EN
    task automatic test_counter();
        // Allocate taken (2) and one more taken update (3) so that two
        // not-taken updates land on 1 (no prediction) and one taken
        // update brings the counter back to 2 (predict taken).
        pc  = {32'h0000_7004, 32'h0000_7000};
        npc = {32'h0000_7008, 32'h0000_7004};
        set_write(1'b1, 1'b0, 32'h0000_1400, 32'h0000_4400, 1'b1); tick();
        set_write(1'b1, 1'b0, 32'h0000_1400, 32'h0000_4400, 1'b1); tick();
        set_write(1'b1, 1'b0, 32'h0000_1400, 32'h0000_4400, 1'b0); tick();
        set_write(1'b1, 1'b0, 32'h0000_1400, 32'h0000_4400, 1'b0); tick();
        set_write(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        pc  = {32'h0000_7000, 32'h0000_1400};
        npc = {32'h0000_7004, 32'h0000_1404};
        tick();
        n_total++;
        if (hit[0] !== 1'b0 || btgt[31:0] !== 32'h0000_1404) begin
            n_bad++;
            $display("FAIL cnt_not_taken: hit0=%b btgt0=%h required hit0=0 btgt0=00001404", hit[0], btgt[31:0]);
        end
        set_write(1'b1, 1'b0, 32'h0000_1400, 32'h0000_4400, 1'b1); tick();
        set_write(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        n_total++;
        if (hit[0] !== 1'b1 || btgt[31:0] !== 32'h0000_4400) begin
            n_bad++;
            $display("FAIL cnt_taken: hit0=%b btgt0=%h required hit0=1 btgt0=00004400", hit[0], btgt[31:0]);
        end
        $display("counter: hit=%b btgt=%h", hit, btgt);
    endtask
`endif

    function automatic logic [31:0] rand_addr();
        return (32'($urandom_range(0, 5)) << 12) | (32'($urandom_range(0, 3)) << 2);
    endfunction

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            set_write($urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0, rand_addr(),
                      $urandom, $urandom_range(0, 3) != 0);
            pc  = {rand_addr(), rand_addr()};
            npc = {32'($urandom), 32'($urandom)};
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (hit[k] !== exp_hit[k] || btgt[k*32 +: 32] !== exp_btgt[k]) begin
                    n_bad++;
                    errs++;
                    $display("FAIL random_lookup: cycle=%0d port=%0d hit=%b btgt=%h required hit=%b btgt=%h",
                             c, k, hit[k], btgt[k*32 +: 32], exp_hit[k], exp_btgt[k]);
                end
            end
        end
        set_write(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        $display("random: 400 cycles, %0d errors", errs);
    endtask

    initial begin
        rst = 1'b1;
        set_write(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        pc  = '0;
        npc = '0;
        #1;
        test_reset();
        test_alloc();
        test_lru();
        test_inv_priority();
        test_hazard();
`ifdef FT64_BTB_ASSOC_CNT_EN
        test_counter();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
